yapp_pkt_tx: RTL and testbench

//  YAPP packet transmitter: the sending end of the YAPP byte interface that feeds yapp_router.
//  - Buffers payload bytes in a FIFO and accepts packet commands (addr, len).
//  - Serialises each command as header, payload bytes, then parity onto in_data/in_data_vld.
//  - Stalls on in_suspend.

---
 rtl/yapp_tx_pkg.sv | 23 ++
 rtl/yapp_pkt_tx_if.sv | 29 ++
 rtl/yapp_tx_fifo.sv | 45 ++++
 rtl/yapp_pkt_tx.sv | 117 +++++++++++
 tb/tb_yapp_pkt_tx.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yapp_tx_pkg.sv
// Shared types, widths and the header-byte helper for the YAPP packet transmitter.
package yapp_tx_pkg;

  localparam int unsigned YAPP_MAX_LEN = 63;
  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned BYTE_W       = 8;

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} tx_state_e;

  // Command fields captured at the accept handshake
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
    logic              bad_par;
  } tx_cmd_t;

  function automatic logic [BYTE_W-1:0] yapp_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/yapp_pkt_tx_if.sv
// Command handshake and YAPP byte stream between a packet source and the transmitter.
// cmd_bad_parity is present only when YAPP_TX_PERR_INJ_EN is defined.
interface yapp_pkt_tx_if;
  import yapp_tx_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
`ifdef YAPP_TX_PERR_INJ_EN
  logic                  cmd_bad_parity;
`endif
  logic [BYTE_W-1:0]     in_data;
  logic                  in_data_vld;
  logic                  in_suspend;

`ifdef YAPP_TX_PERR_INJ_EN
  modport master (output cmd_valid, cmd_addr, cmd_len, cmd_bad_parity, in_suspend,
                  input  cmd_ready, in_data, in_data_vld);
  modport slave  (input  cmd_valid, cmd_addr, cmd_len, cmd_bad_parity, in_suspend,
                  output cmd_ready, in_data, in_data_vld);
`else
  modport master (output cmd_valid, cmd_addr, cmd_len, in_suspend,
                  input  cmd_ready, in_data, in_data_vld);
  modport slave  (input  cmd_valid, cmd_addr, cmd_len, in_suspend,
                  output cmd_ready, in_data, in_data_vld);
`endif

endinterface

// File: rtl/yapp_tx_fifo.sv
// Synchronous byte FIFO holding packet payload; pushes while full are dropped.
module yapp_tx_fifo #(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level,
  output logic          full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Storage carries no reset; only the pointers define validity
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/yapp_pkt_tx.sv
// YAPP packet transmitter: serialises header, buffered payload and parity toward yapp_router.
// Define YAPP_TX_PERR_INJ_EN to enable per-command parity corruption via cmd_bad_parity.
module yapp_pkt_tx
  import yapp_tx_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned IPG   = 1,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            fifo_full,
  output logic [LW-1:0]   fifo_level,
  yapp_pkt_tx_if.slave    tx,
  output logic            busy,
  output logic            pkt_sent,
  output logic [15:0]     pkt_count
);

  tx_state_e         state_q, state_d;
  tx_cmd_t           cmd_q, cmd_in;
  logic [LEN_W-1:0]  rem_q;
  logic [BYTE_W-1:0] par_q;
  logic [3:0]        gap_q;
  logic              armed_q;
  logic [BYTE_W-1:0] fifo_head;
  logic [BYTE_W-1:0] data_c;
  logic              vld_c;
  logic              xfer;
  logic              accept;
  logic              pop;

  yapp_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full)
  );

`ifdef YAPP_TX_PERR_INJ_EN
  assign cmd_in = '{len: tx.cmd_len, addr: tx.cmd_addr, bad_par: tx.cmd_bad_parity};
`else
  assign cmd_in = '{len: tx.cmd_len, addr: tx.cmd_addr, bad_par: 1'b0};
`endif

  // Length is reserved against the FIFO at accept so payload pops never underflow
  assign tx.cmd_ready  = (state_q == IDLE) && armed_q && (fifo_level >= LW'(tx.cmd_len));
  assign accept        = tx.cmd_valid && tx.cmd_ready;
  assign xfer          = vld_c && !tx.in_suspend;
  assign pop           = (state_q == PAYLOAD) && xfer;
  assign tx.in_data    = data_c;
  assign tx.in_data_vld = vld_c;
  assign busy          = (state_q != IDLE);
  assign pkt_sent      = (state_q == PARITY) && xfer;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    data_c  = '0;
    vld_c   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = HEADER;
      HEADER: begin
        vld_c  = 1'b1;
        data_c = yapp_header(cmd_q.len, cmd_q.addr);
        if (!tx.in_suspend) state_d = (cmd_q.len == '0) ? PARITY : PAYLOAD;
      end
      PAYLOAD: begin
        vld_c  = 1'b1;
        data_c = fifo_head;
        if (!tx.in_suspend && rem_q == LEN_W'(1)) state_d = PARITY;
      end
      PARITY: begin
        vld_c  = 1'b1;
        data_c = par_q ^ {BYTE_W{cmd_q.bad_par}};
        if (!tx.in_suspend) state_d = (IPG > 0) ? GAP : IDLE;
      end
      GAP: if (gap_q == 4'(IPG - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, payload countdown, running parity, gap timer and packet counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      cmd_q     <= '0;
      rem_q     <= '0;
      par_q     <= '0;
      gap_q     <= '0;
      pkt_count <= '0;
      armed_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        cmd_q <= cmd_in;
        rem_q <= cmd_in.len;
        par_q <= yapp_header(cmd_in.len, cmd_in.addr);
      end else if (pop) begin
        rem_q <= rem_q - LEN_W'(1);
        par_q <= par_q ^ fifo_head;
      end
      if (pkt_sent) pkt_count <= pkt_count + 16'd1;
      gap_q <= (state_q == GAP) ? gap_q + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_yapp_pkt_tx.sv
// Self-checking bench for yapp_pkt_tx: directed vector table plus randomized traffic vs a queue model.
module tb_yapp_pkt_tx;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IPG   = 2;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          pkt_sent;
  logic [15:0]   pkt_count;

  yapp_pkt_tx_if yif ();

  yapp_pkt_tx #(.DEPTH(DEPTH), .IPG(IPG)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .tx         (yif),
    .busy       (busy),
    .pkt_sent   (pkt_sent),
    .pkt_count  (pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       susp;
    logic [7:0] data;
    logic       vld;
    logic       sent;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  vec_t       vecs [16];
  exp_t       exp_q [$];
  logic [7:0] mq [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_count = 0;
  int         idle_run = 0;
  int         gap_seen = 0;
  int         hdr_cnt = 0;
  bit         rnd_susp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check the byte stream at negedge, then return 1 time unit after posedge
  task automatic cyc();
    exp_t e;
    @(negedge clock);
    if (reset) begin
      if (!yif.in_data_vld) idle_run++;
      else begin
        if (!yif.in_suspend) begin
          if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 1);
          else begin
            e = exp_q.pop_front();
            chk("tx_byte", 32'(yif.in_data), 32'(e.data));
            chk("pkt_sent", 32'(pkt_sent), 32'(e.last));
            if (e.first) begin gap_seen = idle_run; hdr_cnt++; end
            if (e.last) exp_count++;
          end
        end
        idle_run = 0;
      end
    end
    @(posedge clock);
    #1;
    if (rnd_susp) yif.in_suspend = ($urandom_range(0, 3) == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (mq.size() < DEPTH) mq.push_back(b);
    cyc();
    wr_en = 1'b0;
  endtask

  // Reference packet: header = len*4+addr, payload from model FIFO, parity = XOR of all
  task automatic model_cmd(input int addr, input int len, input logic bad);
    logic [7:0] hdr, par, b;
    hdr = 8'(len * 4 + addr);
    par = hdr;
    exp_q.push_back('{hdr, 1'b1, 1'b0});
    for (int i = 0; i < len; i++) begin
      b = (mq.size() == 0) ? 8'h00 : mq.pop_front();
      par = par ^ b;
      exp_q.push_back('{b, 1'b0, 1'b0});
    end
    if (bad) par = ~par;
    exp_q.push_back('{par, 1'b0, 1'b1});
  endtask

  task automatic issue(input int addr, input int len, input logic bad);
    bit got = 0;
    yif.cmd_addr = 2'(addr);
    yif.cmd_len  = 6'(len);
`ifdef YAPP_TX_PERR_INJ_EN
    yif.cmd_bad_parity = bad;
`endif
    yif.cmd_valid = 1'b1;
    model_cmd(addr, len, bad);
    for (int i = 0; i < 400 && !got; i++) begin
      #1;
      if (yif.cmd_ready) got = 1;
      else cyc();
    end
    chk("accept_timeout", 32'(got), 1);
    if (got) cyc();
    yif.cmd_valid = 1'b0;
    yif.cmd_addr  = 2'($urandom);
    yif.cmd_len   = 6'($urandom);
`ifdef YAPP_TX_PERR_INJ_EN
    yif.cmd_bad_parity = 1'($urandom);
`endif
  endtask

  task automatic run_vecs(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      yif.in_suspend = vecs[i].susp;
      #1;
      chk($sformatf("vec%0d_data", i), 32'(yif.in_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_vld", i), 32'(yif.in_data_vld), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_sent", i), 32'(pkt_sent), 32'(vecs[i].sent));
      cyc();
    end
    yif.in_suspend = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_q.size() == 0 && !busy) done = 1;
      else cyc();
    end
    chk("drain_timeout", 32'(done), 1);
  endtask

  initial begin
    logic       bad6;
    logic [7:0] par6;
    int         start;
    int         lvl;
`ifdef YAPP_TX_PERR_INJ_EN
    bad6 = 1'b1; par6 = 8'hFD;
    yif.cmd_bad_parity = 1'b0;
`else
    bad6 = 1'b0; par6 = 8'h02;
`endif
    vecs[0]  = '{1'b0, 8'h0D, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h11, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h22, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h33, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h0D, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h0D, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h11, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h22, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h22, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h22, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h22, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h22, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h33, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h0D, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h02, 1'b1, 1'b0};
    vecs[15] = '{1'b0, par6,  1'b1, 1'b1};

    reset = 1'b0; wr_en = 1'b0; wr_data = '0;
    yif.cmd_valid = 1'b0; yif.cmd_addr = '0; yif.cmd_len = '0; yif.in_suspend = 1'b0;
    cyc(); cyc();
    chk("rst_vld", 32'(yif.in_data_vld), 0);
    chk("rst_data", 32'(yif.in_data), 0);
    chk("rst_ready", 32'(yif.cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sent", 32'(pkt_sent), 0);
    chk("rst_count", 32'(pkt_count), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_full", 32'(fifo_full), 0);
    reset = 1'b1;
    cyc();

    // Basic packet, then the same with a 4-cycle stall on the middle byte
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    issue(1, 3, 1'b0);
    run_vecs(0, 5);
    chk("t1_vld_after", 32'(yif.in_data_vld), 0);
    chk("t1_count", 32'(pkt_count), 1);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    issue(1, 3, 1'b0);
    run_vecs(5, 9);
    chk("t2_count", 32'(pkt_count), 2);

    // Zero-length packet
    issue(2, 0, bad6);
    run_vecs(14, 2);
    drain();

    // cmd_ready waits for enough buffered payload
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    yif.cmd_addr = 2'd1; yif.cmd_len = 6'd5;
    #1;
    chk("t3_ready_lvl3", 32'(yif.cmd_ready), 0);
    push_byte(8'hA4);
    chk("t3_ready_lvl4", 32'(yif.cmd_ready), 0);
    push_byte(8'hA5);
    chk("t3_ready_lvl5", 32'(yif.cmd_ready), 1);
    issue(1, 5, 1'b0);
    chk("t3_header", 32'(yif.in_data), 32'h15);
    drain();
    chk("t3_count", 32'(pkt_count), 32'(exp_count));

    // Back-to-back packets with command held valid: IPG+1 idle cycles
    push_byte(8'h5A); push_byte(8'hA5);
    yif.cmd_addr = 2'd0; yif.cmd_len = 6'd1;
`ifdef YAPP_TX_PERR_INJ_EN
    yif.cmd_bad_parity = 1'b0;
`endif
    yif.cmd_valid = 1'b1;
    model_cmd(0, 1, 1'b0);
    model_cmd(0, 1, 1'b0);
    start = hdr_cnt;
    for (int i = 0; i < 100 && hdr_cnt < start + 2; i++) cyc();
    yif.cmd_valid = 1'b0;
    chk("t5_hdrs", 32'(hdr_cnt - start), 2);
    chk("t5_gap", 32'(gap_seen), IPG + 1);
    drain();

    // Reset in the middle of a payload
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    issue(3, 4, 1'b0);
    cyc(); cyc();
    chk("t4_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    exp_q.delete(); mq.delete(); exp_count = 0;
    cyc();
    chk("t4_vld", 32'(yif.in_data_vld), 0);
    chk("t4_level", 32'(fifo_level), 0);
    chk("t4_count", 32'(pkt_count), 0);
    chk("t4_busy", 32'(busy), 0);
    reset = 1'b1;
    cyc();

    // Overfill, then drain 63+1 to prove the overflow bytes were dropped
    for (int i = 0; i < 70; i++) push_byte(8'(i + 1));
    chk("t7_full", 32'(fifo_full), 1);
    chk("t7_level", 32'(fifo_level), DEPTH);
    issue(0, 63, 1'b0);
    cyc(); cyc(); cyc();
    lvl = int'(fifo_level);
    push_byte(8'hEE);
    chk("t7_push_pop_level", 32'(fifo_level), 32'(lvl));
    drain();
    chk("t7_level_left", 32'(fifo_level), 32'(mq.size()));
    issue(1, 1, 1'b0);
    drain();

    // Randomized traffic with random back-pressure
    rnd_susp = 1;
    for (int p = 0; p < 25; p++) begin
      int   len;
      logic bad;
      len = $urandom_range(0, 16);
`ifdef YAPP_TX_PERR_INJ_EN
      bad = 1'($urandom_range(0, 1));
`else
      bad = 1'b0;
`endif
      for (int i = 0; i < len; i++) push_byte(8'($urandom));
      issue($urandom_range(0, 3), len, bad);
    end
    drain();
    rnd_susp = 0;
    yif.in_suspend = 1'b0;
    cyc();
    chk("rnd_count", 32'(pkt_count), 32'(exp_count));
    chk("rnd_level", 32'(fifo_level), 32'(mq.size()));
    chk("rnd_queue", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
